// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one registered adder among N_REQ requesters.
// Define ADDER_ARBITER_CARRY_EN to add the registered carry-out port rsp_carry.
module adder_arbiter #(
   parameter int WIDTH = 32,
   parameter int N_REQ = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [N_REQ*WIDTH-1:0] req_a,
   input  logic [N_REQ*WIDTH-1:0] req_b,
   output logic [N_REQ-1:0]       rsp_valid,
   input  logic [N_REQ-1:0]       rsp_ready,
`ifdef ADDER_ARBITER_CARRY_EN
   output logic                   rsp_carry,
`endif
   output logic [WIDTH-1:0]       rsp_sum
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam logic [N_REQ-1:0] ONE = N_REQ'(1);
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RESP = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] grant_q, grant_d;
   logic [WIDTH-1:0] sum_q, sum_d;

   logic             found;
   logic [IDX_W-1:0] grant_idx;
   logic [WIDTH-1:0] sel_a, sel_b, sum_acc;
   logic             rsp_take;

`ifdef ADDER_ARBITER_CARRY_EN
   logic carry_q, carry_d, carry_acc;
   assign rsp_carry = carry_q;
`endif

   // First valid requester at or above ptr, wrapping past the top index.
   always_comb begin
      int cand;
      logic [IDX_W-1:0] idx_c;
      found     = 1'b0;
      grant_idx = ptr_q;
      cand      = 0;
      idx_c     = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = int'(ptr_q) + k;
         if (cand >= N_REQ) cand = cand - N_REQ;
         idx_c = IDX_W'(cand);
         if (!found && req_valid[idx_c]) begin
            found     = 1'b1;
            grant_idx = idx_c;
         end
      end
   end

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (IDX_W'(i) == grant_idx) begin
            sel_a = req_a[i*WIDTH +: WIDTH];
            sel_b = req_b[i*WIDTH +: WIDTH];
         end
      end
`ifdef ADDER_ARBITER_CARRY_EN
      {carry_acc, sum_acc} = {1'b0, sel_a} + {1'b0, sel_b};
`else
      sum_acc = sel_a + sel_b;
`endif
   end

   assign rsp_valid = (state_q == ST_RESP) ? (ONE << grant_q) : '0;
   assign rsp_sum   = sum_q;
   assign rsp_take  = |(rsp_valid & rsp_ready);

   // The pointer only advances when a response completes, never on acceptance.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      grant_d   = grant_q;
      sum_d     = sum_q;
      req_ready = '0;
`ifdef ADDER_ARBITER_CARRY_EN
      carry_d   = carry_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (found && !reset) begin
               req_ready = ONE << grant_idx;
               grant_d   = grant_idx;
               sum_d     = sum_acc;
`ifdef ADDER_ARBITER_CARRY_EN
               carry_d   = carry_acc;
`endif
               state_d   = ST_RESP;
            end
         end
         default: begin
            if (rsp_take) begin
               state_d = ST_IDLE;
               ptr_d   = (grant_q == IDX_W'(N_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         sum_q   <= '0;
`ifdef ADDER_ARBITER_CARRY_EN
         carry_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         sum_q   <= sum_d;
`ifdef ADDER_ARBITER_CARRY_EN
         carry_q <= carry_d;
`endif
      end
   end

endmodule
